// File: rtl/bpu_pkg.sv
// Shared types and the saturating 2-bit counter update for the branch predictor.
package bpu_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } pht_ctr_t;

    localparam pht_ctr_t PHT_RESET = WEAK_NT;

    function automatic pht_ctr_t pht_next(pht_ctr_t c, logic taken);
        pht_ctr_t n;
        n = c;
        if (taken && (c != STRONG_T)) begin
            n = pht_ctr_t'(c + 2'd1);
        end else if (!taken && (c != STRONG_NT)) begin
            n = pht_ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2**IndexBits saturating counters, one async read port and one
// training port.
module bpu_pht
    import bpu_pkg::*;
#(
    parameter int unsigned IndexBits = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IndexBits-1:0] rd_idx,
    output pht_ctr_t             rd_ctr,
    input  logic                 upd_en,
    input  logic [IndexBits-1:0] upd_idx,
    input  logic                 upd_taken
);

    localparam int unsigned Depth = 2 ** IndexBits;

    pht_ctr_t pht_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else if (upd_en) begin
            pht_q[upd_idx] <= pht_next(pht_q[upd_idx], upd_taken);
        end
    end

    // Reads the pre-update value when the same entry is trained this cycle.
    assign rd_ctr = pht_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Per-PC 2-bit branch predictor with mispredict flush and corrected-PC generation.
// Define BPU_GSHARE_EN to XOR a global history register into the PHT index.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int unsigned WordSize  = 32,
    parameter int unsigned IndexBits = 6,
    parameter int unsigned HistBits  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WordSize-1:0]  fetch_pc,
    output logic                 pred_taken,
    output logic [IndexBits-1:0] pred_idx,
    input  logic                 res_valid,
    input  logic [IndexBits-1:0] res_idx,
    input  logic                 res_taken,
    input  logic                 res_pred_taken,
    input  logic [WordSize-1:0]  res_target,
    input  logic [WordSize-1:0]  res_npc,
    output logic                 flush,
    output logic [WordSize-1:0]  npc_corr,
    output logic [31:0]          mispred_cnt
);

    logic [IndexBits-1:0] pc_idx;
    pht_ctr_t             rd_ctr;
    logic                 mispredict;
    logic                 flush_d, flush_q;
    logic [WordSize-1:0]  npc_d, npc_q;
    logic [31:0]          cnt_d, cnt_q;

    assign pc_idx = fetch_pc[IndexBits+1:2];

`ifdef BPU_GSHARE_EN
    logic [HistBits-1:0] ghr_q;
    logic                unused_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (res_valid) begin
            ghr_q <= HistBits'({ghr_q, res_taken});
        end
    end

    assign pred_idx  = pc_idx ^ IndexBits'(ghr_q);
    assign unused_pc = ^{fetch_pc[WordSize-1:IndexBits+2], fetch_pc[1:0]};
`else
    logic unused_pc;

    assign pred_idx  = pc_idx;
    assign unused_pc = ^{fetch_pc[WordSize-1:IndexBits+2], fetch_pc[1:0], 1'(HistBits)};
`endif

    bpu_pht #(
        .IndexBits (IndexBits)
    ) u_pht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pred_idx),
        .rd_ctr    (rd_ctr),
        .upd_en    (res_valid),
        .upd_idx   (res_idx),
        .upd_taken (res_taken)
    );

    assign pred_taken = rd_ctr[1];
    assign mispredict = res_valid && (res_taken != res_pred_taken);

    always_comb begin
        flush_d = mispredict;
        npc_d   = npc_q;
        cnt_d   = cnt_q;
        if (mispredict) begin
            npc_d = res_taken ? res_target : res_npc;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= 1'b0;
            npc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            flush_q <= flush_d;
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush       = flush_q;
    assign npc_corr    = npc_q;
    assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a scoreboard of expected flush/npc/count results.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [5:0]  pred_idx;
    logic        res_valid;
    logic [5:0]  res_idx;
    logic        res_taken;
    logic        res_pred_taken;
    logic [31:0] res_target;
    logic [31:0] res_npc;
    logic        flush;
    logic [31:0] npc_corr;
    logic [31:0] mispred_cnt;

    typedef struct {
        logic        flush;
        logic [31:0] npc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_npc = '0;
    logic [31:0] m_cnt = '0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .WordSize  (32),
        .IndexBits (6),
        .HistBits  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_idx       (pred_idx),
        .res_valid      (res_valid),
        .res_idx        (res_idx),
        .res_taken      (res_taken),
        .res_pred_taken (res_pred_taken),
        .res_target     (res_target),
        .res_npc        (res_npc),
        .flush          (flush),
        .npc_corr       (npc_corr),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one resolution and push what the registered outputs must show after the edge.
    task automatic drive(input logic [5:0] idx, input logic taken, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] npc);
        exp_t e;
        res_valid      = 1'b1;
        res_idx        = idx;
        res_taken      = taken;
        res_pred_taken = pred;
        res_target     = tgt;
        res_npc        = npc;
        e.flush = (taken != pred);
        if (e.flush) begin
            m_npc = taken ? tgt : npc;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        e.npc = m_npc;
        e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic finish_cycle(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_flush"}, {31'd0, flush}, {31'd0, e.flush});
            check({tag, "_npc"}, npc_corr, e.npc);
            check({tag, "_cnt"}, mispred_cnt, e.cnt);
        end
    endtask

    task automatic resolve(input string tag, input logic [5:0] idx, input logic taken,
                           input logic pred, input logic [31:0] tgt, input logic [31:0] npc);
        drive(idx, taken, pred, tgt, npc);
        finish_cycle(tag);
    endtask

    task automatic idle(input string tag);
        exp_t e;
        res_valid = 1'b0;
        e.flush = 1'b0;
        e.npc   = m_npc;
        e.cnt   = m_cnt;
        sb_q.push_back(e);
        finish_cycle(tag);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic [5:0] idx,
                              input logic exp_taken);
        fetch_pc = pc;
        #1;
        check({tag, "_idx"}, {26'd0, pred_idx}, {26'd0, idx});
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    endtask

    initial begin
        rst            = 1'b1;
        fetch_pc       = 32'h0000_0040;
        res_valid      = 1'b0;
        res_idx        = '0;
        res_taken      = 1'b0;
        res_pred_taken = 1'b0;
        res_target     = '0;
        res_npc        = '0;
        #12;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_idx", {26'd0, pred_idx}, 32'h10);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_cnt", mispred_cnt, 32'd0);
        check("rst_npc", npc_corr, 32'd0);
        rst = 1'b0;

        // Train up: WEAK_NT -> WEAK_T (mispredict) -> STRONG_T.
        resolve("t1", 6'h10, 1'b1, 1'b0, 32'h100, 32'h44);
        check_pred("t1p", 32'h40, 6'h10, 1'b1);
        resolve("t2", 6'h10, 1'b1, 1'b1, 32'h100, 32'h44);
        check_pred("t2p", 32'h40, 6'h10, 1'b1);
        idle("i1");

        // Train down to STRONG_NT and saturate.
        resolve("n1", 6'h10, 1'b0, 1'b1, 32'h200, 32'h48);
        check_pred("n1p", 32'h40, 6'h10, 1'b1);
        resolve("n2", 6'h10, 1'b0, 1'b0, 32'h200, 32'h48);
        check_pred("n2p", 32'h40, 6'h10, 1'b0);
        resolve("n3", 6'h10, 1'b0, 1'b0, 32'h200, 32'h48);
        resolve("n4", 6'h10, 1'b0, 1'b0, 32'h200, 32'h48);
        check_pred("n4p", 32'h40, 6'h10, 1'b0);

        // Two back-to-back mispredicts: flush stays high two cycles; STRONG_NT -> WEAK_T.
        resolve("b1", 6'h10, 1'b1, 1'b0, 32'h300, 32'h4C);
        check_pred("b1p", 32'h40, 6'h10, 1'b0);
        resolve("b2", 6'h10, 1'b1, 1'b0, 32'h340, 32'h50);
        check_pred("b2p", 32'h40, 6'h10, 1'b1);
        idle("i2");

        // Same-cycle update and lookup: old value now, new value after the edge.
        fetch_pc = 32'h40;
        drive(6'h10, 1'b0, 1'b1, 32'h400, 32'h54);
        #1;
        check("same_old", {31'd0, pred_taken}, 32'd1);
        finish_cycle("same");
        check("same_new", {31'd0, pred_taken}, 32'd0);

        // Other entries untouched; upper PC bits ignored.
        check_pred("oth1", 32'h80, 6'h20, 1'b0);
        check_pred("oth2", 32'h1000_0044, 6'h11, 1'b0);

        // Reset while flush is high.
        resolve("r1", 6'h10, 1'b1, 1'b0, 32'h500, 32'h58);
        fetch_pc = 32'h40;
        #1;
        check("r1_pre_taken", {31'd0, pred_taken}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rmid_flush", {31'd0, flush}, 32'd0);
        check("rmid_npc", npc_corr, 32'd0);
        check("rmid_cnt", mispred_cnt, 32'd0);
        check("rmid_taken", {31'd0, pred_taken}, 32'd0);
        m_npc = '0;
        m_cnt = '0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        resolve("r2", 6'h10, 1'b1, 1'b0, 32'h600, 32'h5C);
        check_pred("r2p", 32'h40, 6'h10, 1'b1);

`ifdef BPU_GSHARE_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_npc = '0;
        m_cnt = '0;
        resolve("g1", 6'h00, 1'b1, 1'b1, 32'h700, 32'h04);
        resolve("g2", 6'h00, 1'b1, 1'b1, 32'h700, 32'h04);
        fetch_pc = 32'h40;
        #1;
        check("gshare_idx", {26'd0, pred_idx}, 32'h13);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
